// File: rtl/accel_csr_regfile.sv
// CSR register bank for one accelerator core: control, status, cycle counter, ID and argument registers.
// Optional macro CSR_ARG_LOCK_EN rejects argument writes while the core is busy.
module accel_csr_regfile #(
  parameter int                  ADDR_WIDTH = 12,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  N_ARGS     = 4,
  parameter logic [DATA_WIDTH-1:0] BLOCK_ID = 32'hACC0_0001
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic [ADDR_WIDTH-1:0]        csr_addr,
  input  logic                         csr_ren,
  output logic [DATA_WIDTH-1:0]        csr_rdata,
  input  logic                         csr_wen,
  input  logic [DATA_WIDTH-1:0]        csr_wdata,
  output logic                         csr_waddr_error,
  output logic                         csr_raddr_error,
  output logic                         core_go,
  input  logic                         core_done,
  output logic [N_ARGS*DATA_WIDTH-1:0] core_args,
  output logic                         irq
);

  localparam logic [DATA_WIDTH-1:0] ONE     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [31:0]           ARG_END = 32'(32 + 4 * N_ARGS);

  logic [DATA_WIDTH-1:0] r_args [N_ARGS];
  logic [DATA_WIDTH-1:0] r_cycles;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_irq_en;
  logic                  r_irq;
  logic                  r_go;
  logic                  r_waddr_err;
  logic                  r_raddr_err;

  logic [31:0]           w_addr32;
  logic [2:0]            w_arg_idx;
  logic                  w_aligned;
  logic                  w_hit_ctrl;
  logic                  w_hit_status;
  logic                  w_hit_cycles;
  logic                  w_hit_id;
  logic                  w_hit_arg;
  logic                  w_dec_err;
  logic                  w_lock_err;
  logic                  w_werr;
  logic                  w_wr_ok;
  logic                  w_start;
  logic                  w_done_evt;
  logic                  w_done_clr;
  logic [DATA_WIDTH-1:0] w_rvalue;

  assign w_addr32     = 32'(csr_addr);
  assign w_arg_idx    = 3'((w_addr32 - 32'h20) >> 2);
  assign w_aligned    = (csr_addr[1:0] == 2'b00);
  assign w_hit_ctrl   = w_aligned && (w_addr32 == 32'h000);
  assign w_hit_status = w_aligned && (w_addr32 == 32'h004);
  assign w_hit_cycles = w_aligned && (w_addr32 == 32'h008);
  assign w_hit_id     = w_aligned && (w_addr32 == 32'h00C);
  assign w_hit_arg    = w_aligned && (w_addr32 >= 32'h020) && (w_addr32 < ARG_END);
  assign w_dec_err    = !(w_hit_ctrl || w_hit_status || w_hit_cycles || w_hit_id || w_hit_arg);

`ifdef CSR_ARG_LOCK_EN
  // Arguments are frozen while the core may still be consuming them.
  assign w_lock_err = w_hit_arg && r_busy;
`else
  assign w_lock_err = 1'b0;
`endif

  assign w_werr     = w_dec_err || w_lock_err;
  assign w_wr_ok    = csr_wen && !w_werr;
  assign w_start    = w_wr_ok && w_hit_ctrl && csr_wdata[0] && !r_busy;
  assign w_done_evt = core_done && r_busy;
  assign w_done_clr = w_wr_ok && w_hit_status && csr_wdata[1];

  always_comb begin
    w_rvalue = '0;
    if (w_hit_ctrl)   w_rvalue = {{(DATA_WIDTH-2){1'b0}}, r_irq_en, 1'b0};
    if (w_hit_status) w_rvalue = {{(DATA_WIDTH-2){1'b0}}, r_done, r_busy};
    if (w_hit_cycles) w_rvalue = r_cycles;
    if (w_hit_id)     w_rvalue = BLOCK_ID;
    for (int i = 0; i < N_ARGS; i++) begin
      if (w_hit_arg && (w_arg_idx == 3'(i))) w_rvalue = r_args[i];
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_cycles    <= '0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_irq_en    <= 1'b0;
      r_irq       <= 1'b0;
      r_go        <= 1'b0;
      r_waddr_err <= 1'b0;
      r_raddr_err <= 1'b0;
      for (int i = 0; i < N_ARGS; i++) r_args[i] <= '0;
    end else begin
      r_go  <= w_start;
      r_irq <= r_done && r_irq_en;

      if (w_wr_ok && w_hit_ctrl) r_irq_en <= csr_wdata[1];

      // The done edge itself is not counted, so CYCLES freezes at the busy length.
      if (w_start) begin
        r_busy   <= 1'b1;
        r_cycles <= '0;
      end else if (r_busy) begin
        if (core_done)         r_busy   <= 1'b0;
        else if (~&r_cycles)   r_cycles <= r_cycles + ONE;
      end

      if (w_start)          r_done <= 1'b0;
      else if (w_done_evt)  r_done <= 1'b1;
      else if (w_done_clr)  r_done <= 1'b0;

      for (int i = 0; i < N_ARGS; i++) begin
        if (w_wr_ok && w_hit_arg && (w_arg_idx == 3'(i))) r_args[i] <= csr_wdata;
      end

      if (csr_wen) r_waddr_err <= w_werr;

      if (csr_ren) begin
        r_rdata     <= w_dec_err ? '0 : w_rvalue;
        r_raddr_err <= w_dec_err;
      end
    end
  end

  always_comb begin
    core_args = '0;
    for (int i = 0; i < N_ARGS; i++) core_args[i*DATA_WIDTH +: DATA_WIDTH] = r_args[i];
  end

  assign csr_rdata       = r_rdata;
  assign csr_waddr_error = r_waddr_err;
  assign csr_raddr_error = r_raddr_err;
  assign core_go         = r_go;
  assign irq             = r_irq;

endmodule
